sr_latch_ctrl: RTL and testbench

- Sequencer and arbiter for a bank of N cross-coupled SR latches.
- Two clocked requesters ask to set or clear one latch.
- The block grants one requester at a time and drives a timed S or R pulse to the addressed latch.
- It guarantees s[i] and r[i] are never high together, and never high on two latches at once.
- It sits between synchronous control logic and the asynchronous latch bank.

---
 rtl/sr_ctrl_pkg.sv | 21 ++
 rtl/sr_rr_arb2.sv | 25 ++
 rtl/sr_latch_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch bank sequencer.
package sr_ctrl_pkg;

    // Sequencer phases: waiting for a request, driving S or R, quiet gap after a pulse.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    // Requested operation encoding.
    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Identifies which of the two requesters owns the current operation.
    typedef logic grant_id_t;

    localparam grant_id_t GID_REQ0 = 1'b0;
    localparam grant_id_t GID_REQ1 = 1'b1;

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, and on a tie the
// requester that was not granted last time wins.
module sr_rr_arb2
    import sr_ctrl_pkg::*;
(
    input  logic      req0,
    input  logic      req1,
    input  grant_id_t last_grant,
    input  logic      en,
    output logic      gnt_valid,
    output grant_id_t gnt_id
);

    // Pick the winner; ties alternate away from the previous winner.
    always_comb begin
        gnt_valid = en && (req0 || req1);
        gnt_id    = GID_REQ0;
        if (req0 && req1) begin
            gnt_id = ~last_grant;
        end else if (req1) begin
            gnt_id = GID_REQ1;
        end
    end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer/arbiter driving timed S or R pulses into a bank of N SR latches.
// Optional readback compare of latch outputs is enabled by SR_READBACK_CHECK_EN.
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int N         = 4,
    parameter int IW        = (N > 1) ? $clog2(N) : 1,
    parameter int PULSE_CYC = 2,
    parameter int REC_CYC   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          op0,
    input  logic [IW-1:0] idx0,
    output logic          ack0,
    input  logic          req1,
    input  logic          op1,
    input  logic [IW-1:0] idx1,
    output logic          ack1,
    output logic [N-1:0]  s,
    output logic [N-1:0]  r,
    output logic          busy,
`ifdef SR_READBACK_CHECK_EN
    input  logic [N-1:0]  q_fb,
    output logic          err,
`endif
    output logic [N-1:0]  shadow
);

    localparam int CNT_MAX = (PULSE_CYC > REC_CYC) ? PULSE_CYC : REC_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] P_LOAD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] R_LOAD  = CNT_W'(REC_CYC - 1);
    localparam logic [N-1:0]     ONE_BIT = N'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    grant_id_t        gid_q, gid_d;
    grant_id_t        last_grant_q, last_grant_d;
    logic [N-1:0]     s_q, s_d;
    logic [N-1:0]     r_q, r_d;
    logic [N-1:0]     shadow_q, shadow_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
`ifdef SR_READBACK_CHECK_EN
    logic             err_q, err_d;
`endif

    logic             arb_en;
    logic             gnt_valid;
    grant_id_t        gnt_id;
    logic             gnt_op;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_idx_ok;
    logic [N-1:0]     gnt_mask;
    logic [N-1:0]     cur_mask;
    logic             ack_fire;
    grant_id_t        ack_id;

    // Arbitration only happens in IDLE, and not during an out-of-range ack cycle,
    // so a requester still holding req through its ack is not served twice.
    assign arb_en = (state_q == IDLE) && !ack0_q && !ack1_q;

    sr_rr_arb2 u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .en         (arb_en),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign gnt_op     = (gnt_id == GID_REQ1) ? op1 : op0;
    assign gnt_idx    = (gnt_id == GID_REQ1) ? idx1 : idx0;
    assign gnt_idx_ok = (int'(gnt_idx) < N);
    assign gnt_mask   = ONE_BIT << gnt_idx;
    assign cur_mask   = ONE_BIT << idx_q;

    // Next-state logic: S/R default low so only one bit of one bus can ever be high.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        idx_d        = idx_q;
        gid_d        = gid_q;
        last_grant_d = last_grant_q;
        s_d          = '0;
        r_d          = '0;
        shadow_d     = shadow_q;
        ack_fire     = 1'b0;
        ack_id       = gid_q;
`ifdef SR_READBACK_CHECK_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    op_d         = gnt_op;
                    idx_d        = gnt_idx;
                    gid_d        = gnt_id;
                    last_grant_d = gnt_id;
                    if (gnt_idx_ok) begin
                        state_d = PULSE;
                        cnt_d   = P_LOAD;
                        s_d     = (gnt_op == OP_SET) ? gnt_mask : '0;
                        r_d     = (gnt_op == OP_SET) ? '0 : gnt_mask;
                    end else begin
                        ack_fire = 1'b1;
                        ack_id   = gnt_id;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = R_LOAD;
                    if (R_LOAD == '0) begin
                        ack_fire = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    s_d   = (op_q == OP_SET) ? cur_mask : '0;
                    r_d   = (op_q == OP_SET) ? '0 : cur_mask;
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d  = IDLE;
                    shadow_d = (op_q == OP_SET) ? (shadow_q | cur_mask) : (shadow_q & ~cur_mask);
`ifdef SR_READBACK_CHECK_EN
                    if ((|(q_fb & cur_mask)) != op_q) begin
                        err_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        ack_fire = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ack0_d = ack_fire && (ack_id == GID_REQ0);
        ack1_d = ack_fire && (ack_id == GID_REQ1);
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops every drive immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= OP_CLR;
            idx_q        <= '0;
            gid_q        <= GID_REQ0;
            last_grant_q <= GID_REQ1;
            s_q          <= '0;
            r_q          <= '0;
            shadow_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SR_READBACK_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            gid_q        <= gid_d;
            last_grant_q <= last_grant_d;
            s_q          <= s_d;
            r_q          <= r_d;
            shadow_q     <= shadow_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
`ifdef SR_READBACK_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign s      = s_q;
    assign r      = r_q;
    assign shadow = shadow_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign busy   = busy_q;
`ifdef SR_READBACK_CHECK_EN
    assign err    = err_q;
`endif

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed and randomized bench for sr_latch_ctrl (N=4, 3-bit index so that
// out-of-range indices can be presented). Readback checks run when
// SR_READBACK_CHECK_EN is defined.
module tb_sr_latch_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] reqV;
    logic [1:0] opV;
    logic [2:0] idxV [2];
    logic       ack0;
    logic       ack1;
    logic [3:0] s;
    logic [3:0] r;
    logic       busy;
    logic [3:0] shadow;
`ifdef SR_READBACK_CHECK_EN
    logic [3:0] qFb;
    logic       err;
`endif

    int compareCount = 0;
    int errCount     = 0;

    sr_latch_ctrl #(
        .N         (4),
        .IW        (3),
        .PULSE_CYC (2),
        .REC_CYC   (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (reqV[0]),
        .op0    (opV[0]),
        .idx0   (idxV[0]),
        .ack0   (ack0),
        .req1   (reqV[1]),
        .op1    (opV[1]),
        .idx1   (idxV[1]),
        .ack1   (ack1),
        .s      (s),
        .r      (r),
        .busy   (busy),
`ifdef SR_READBACK_CHECK_EN
        .q_fb   (qFb),
        .err    (err),
`endif
        .shadow (shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a bounded wait is somehow skipped.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int who, input logic req, input logic op, input logic [2:0] idx);
        reqV[who] = req;
        opV[who]  = op;
        idxV[who] = idx;
    endtask

    task automatic doReset();
        rst = 1'b1;
        reqV = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait a bounded number of cycles for one requester's ack, then drop its req.
    task automatic waitAck(input int who, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if ((who == 0 && ack0) || (who == 1 && ack1)) seen = 1'b1;
        end
        checkOutput(tag, {31'd0, seen}, 32'd1);
        reqV[who] = 1'b0;
    endtask

    logic [3:0] modelShadow;
    int         waitCnt [2];
    int         reqTotal;
    int         ackTotal;
    bit         stuck;
    logic       ackK;

    initial begin
        rst = 1'b0;
        reqV = 2'b00;
        opV = 2'b00;
        idxV[0] = 3'd0;
        idxV[1] = 3'd0;
`ifdef SR_READBACK_CHECK_EN
        qFb = 4'h0;
`endif
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_s", {28'd0, s}, 32'h0);
        checkOutput("rst_async_r", {28'd0, r}, 32'h0);
        doReset();
        checkOutput("rst_ack0", {31'd0, ack0}, 32'd0);
        checkOutput("rst_ack1", {31'd0, ack1}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_shadow", {28'd0, shadow}, 32'h0);

        // Single set of latch 2: pulse in cycles 1-2, ack in cycle 3.
        applyStimulus(0, 1'b1, 1'b1, 3'd2);
        tick();
        checkOutput("set2_c1_s", {28'd0, s}, 32'h4);
        checkOutput("set2_c1_r", {28'd0, r}, 32'h0);
        checkOutput("set2_c1_busy", {31'd0, busy}, 32'd1);
        checkOutput("set2_c1_ack0", {31'd0, ack0}, 32'd0);
        tick();
        checkOutput("set2_c2_s", {28'd0, s}, 32'h4);
        tick();
        checkOutput("set2_c3_s", {28'd0, s}, 32'h0);
        checkOutput("set2_c3_ack0", {31'd0, ack0}, 32'd1);
        checkOutput("set2_c3_ack1", {31'd0, ack1}, 32'd0);
        reqV[0] = 1'b0;
        tick();
        checkOutput("set2_c4_shadow", {28'd0, shadow}, 32'h4);
        checkOutput("set2_c4_busy", {31'd0, busy}, 32'd0);
        checkOutput("set2_c4_ack0", {31'd0, ack0}, 32'd0);

        // Tie after reset: requester 0 first, then a second tie goes to requester 1.
        doReset();
        applyStimulus(0, 1'b1, 1'b1, 3'd0);
        applyStimulus(1, 1'b1, 1'b0, 3'd3);
        tick();
        checkOutput("tie_c1_s", {28'd0, s}, 32'h1);
        checkOutput("tie_c1_r", {28'd0, r}, 32'h0);
        tick();
        tick();
        checkOutput("tie_c3_ack0", {31'd0, ack0}, 32'd1);
        checkOutput("tie_c3_ack1", {31'd0, ack1}, 32'd0);
        applyStimulus(0, 1'b1, 1'b1, 3'd1);
        tick();
        checkOutput("tie_c4_busy", {31'd0, busy}, 32'd0);
        checkOutput("tie_c4_shadow", {28'd0, shadow}, 32'h1);
        tick();
        checkOutput("tie_c5_r", {28'd0, r}, 32'h8);
        checkOutput("tie_c5_s", {28'd0, s}, 32'h0);
        tick();
        tick();
        checkOutput("tie_c7_ack1", {31'd0, ack1}, 32'd1);
        checkOutput("tie_c7_ack0", {31'd0, ack0}, 32'd0);
        reqV[1] = 1'b0;
        tick();
        checkOutput("tie_c8_shadow", {28'd0, shadow}, 32'h1);
        tick();
        checkOutput("tie_c9_s", {28'd0, s}, 32'h2);
        tick();
        tick();
        checkOutput("tie_c11_ack0", {31'd0, ack0}, 32'd1);
        reqV[0] = 1'b0;
        tick();
        checkOutput("tie_c12_shadow", {28'd0, shadow}, 32'h3);

        // Out-of-range index: no pulse, ack one cycle after grant, shadow kept.
        applyStimulus(0, 1'b1, 1'b1, 3'd5);
        tick();
        checkOutput("oob_c1_ack0", {31'd0, ack0}, 32'd1);
        checkOutput("oob_c1_sr", {28'd0, s | r}, 32'h0);
        checkOutput("oob_c1_busy", {31'd0, busy}, 32'd0);
        reqV[0] = 1'b0;
        tick();
        checkOutput("oob_c2_ack0", {31'd0, ack0}, 32'd0);
        checkOutput("oob_c2_shadow", {28'd0, shadow}, 32'h3);
        checkOutput("oob_c2_sr", {28'd0, s | r}, 32'h0);

        // Reset in the middle of a pulse truncates it with no ack.
        applyStimulus(0, 1'b1, 1'b1, 3'd2);
        tick();
        checkOutput("midrst_c1_s", {28'd0, s}, 32'h4);
        rst = 1'b1;
        #1;
        checkOutput("midrst_s", {28'd0, s}, 32'h0);
        checkOutput("midrst_r", {28'd0, r}, 32'h0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_shadow", {28'd0, shadow}, 32'h0);
        checkOutput("midrst_ack0", {31'd0, ack0}, 32'd0);
        reqV[0] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("midrst_after_ack0", {31'd0, ack0}, 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 3'd1);
        applyStimulus(1, 1'b1, 1'b1, 3'd2);
        tick();
        checkOutput("postrst_tie_r", {28'd0, r}, 32'h2);
        checkOutput("postrst_tie_s", {28'd0, s}, 32'h0);
        waitAck(0, "postrst_ack0");
        waitAck(1, "postrst_ack1");
        tick();
        checkOutput("postrst_shadow", {28'd0, shadow}, 32'h4);

        // Random back-to-back traffic against a shadow model.
        doReset();
        modelShadow = 4'h0;
        reqTotal = 0;
        ackTotal = 0;
        waitCnt[0] = 0;
        waitCnt[1] = 0;
        stuck = 1'b0;
        for (int cyc = 0; cyc < 1100 && !stuck; cyc++) begin
            tick();
            checkOutput("rand_s_and_r", {28'd0, s & r}, 32'h0);
            checkOutput("rand_onehot", {31'd0, ($countones(s | r) <= 1)}, 32'd1);
            checkOutput("rand_shadow", {28'd0, shadow}, {28'd0, modelShadow});
            for (int k = 0; k < 2; k++) begin
                ackK = (k == 0) ? ack0 : ack1;
                if (ackK) begin
                    checkOutput("rand_ack_has_req", {31'd0, reqV[k]}, 32'd1);
                    if (reqV[k] && idxV[k] < 3'd4) begin
                        modelShadow = opV[k] ? (modelShadow | (4'b0001 << idxV[k]))
                                             : (modelShadow & ~(4'b0001 << idxV[k]));
                    end
                    ackTotal++;
                    reqV[k] = 1'b0;
                    waitCnt[k] = 0;
                end else if (reqV[k]) begin
                    waitCnt[k]++;
                    if (waitCnt[k] > 40) begin
                        checkOutput("rand_ack_timeout", 32'd0, 32'd1);
                        stuck = 1'b1;
                    end
                end else if (cyc < 1000 && $urandom_range(0, 3) == 0) begin
                    applyStimulus(k, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)));
                    reqTotal++;
                end
            end
        end
        checkOutput("rand_drained", {30'd0, reqV}, 32'd0);
        checkOutput("rand_ack_count", ackTotal, reqTotal);
        reqV = 2'b00;

`ifdef SR_READBACK_CHECK_EN
        // Readback with latch outputs stuck low: err rises after the ack and sticks.
        doReset();
        qFb = 4'h0;
        checkOutput("rb_rst_err", {31'd0, err}, 32'd0);
        applyStimulus(0, 1'b1, 1'b1, 3'd1);
        tick();
        tick();
        tick();
        checkOutput("rb_c3_ack0", {31'd0, ack0}, 32'd1);
        checkOutput("rb_c3_err", {31'd0, err}, 32'd0);
        reqV[0] = 1'b0;
        tick();
        checkOutput("rb_c4_err", {31'd0, err}, 32'd1);
        tick();
        tick();
        tick();
        checkOutput("rb_held_err", {31'd0, err}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rb_rst_clears_err", {31'd0, err}, 32'd0);
        tick();
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
        $finish;
    end

endmodule
